// File: rtl/note_track_sequencer.sv
// rtl/note_track_sequencer.sv - chart ROM fetch, chunk load and tempo shift sequencer for the note-track shifter
//
// Purpose:
//   Plays a chart of chart_len chunks of WIDTH bits back to back into an external
//   WIDTH-bit shifter. Each chunk is loaded with a one-cycle active-low load strobe.
//   The sequencer then issues WIDTH shift strobes spaced TICKS_PER_SHIFT clocks apart.
//   While the current chunk plays, the next chunk is prefetched from the sync ROM.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   start       in   begin playback (only honoured in IDLE)
//   pause       in   level, freezes the tempo tick counter while playing
//   chart_len   in   number of chunks, latched on accepted start
//   chart_addr  out  chart ROM address (registered)
//   chart_data  in   chart ROM data, valid one clock after chart_addr
//   load_val    out  chunk presented to the shifter parallel load
//   load_n      out  active-low one-cycle load strobe
//   shift       out  one-cycle shift strobe
//   shift_in    out  shifter serial input, tied low
//   busy        out  high whenever not IDLE
//   done        out  one-cycle pulse at end of chart
//   chunk_idx   out  index of chunk currently in the shifter
//   step_idx    out  shifts issued within the current chunk

module note_track_sequencer #(
  parameter int WIDTH           = 100,
  parameter int TICKS_PER_SHIFT = 833333,
  parameter int ADDR_W          = 6,
  parameter int STEP_W          = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  input  logic [ADDR_W-1:0] chart_len,
  output logic [ADDR_W-1:0] chart_addr,
  input  logic [WIDTH-1:0]  chart_data,
  output logic [WIDTH-1:0]  load_val,
  output logic              load_n,
  output logic              shift,
  output logic              shift_in,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] chunk_idx,
  output logic [STEP_W-1:0] step_idx
);

  localparam int TICK_W = (TICKS_PER_SHIFT > 1) ? $clog2(TICKS_PER_SHIFT) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SHIFT - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_FILL,
    S_LOAD,
    S_RUN,
    S_FIN
  } state_t;

  state_t state, state_nxt;

  logic [TICK_W-1:0] tick;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] next_chunk;
  logic [WIDTH-1:0]  chunk_buf;
  logic              pf_a, pf_b;   // prefetch pipeline: address issued, ROM data arriving
  logic              tick_last;
  logic              step_last;
  logic              more_chunks;
  logic              shift_fire;

  assign next_chunk  = chunk_idx + 1'b1;
  assign more_chunks = (next_chunk < len_q);
  assign tick_last   = (tick == TICK_LAST);
  assign step_last   = (step_idx == STEP_LAST);
  // A paused tick never fires, so a shift can only come from a counted clock.
  assign shift_fire  = (state == S_RUN) && !pause && tick_last;
  assign shift_in    = 1'b0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_n    = 1'b1;
    shift     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = (chart_len != '0) ? S_PRIME : S_FIN;
        end
      end
      S_PRIME: state_nxt = S_FILL;
      S_FILL:  state_nxt = S_LOAD;
      S_LOAD: begin
        load_n    = 1'b0;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (shift_fire) begin
          shift = 1'b1;
          if (step_last) begin
            state_nxt = more_chunks ? S_LOAD : S_FIN;
          end
        end
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      chart_addr <= '0;
      chunk_idx  <= '0;
      step_idx   <= '0;
      tick       <= '0;
      len_q      <= '0;
      load_val   <= '0;
      chunk_buf  <= '0;
      pf_a       <= 1'b0;
      pf_b       <= 1'b0;
    end else begin
      pf_a <= (state == S_LOAD) && more_chunks;
      pf_b <= pf_a;
      if (pf_b) begin
        chunk_buf <= chart_data;
      end

      // load_val is updated on the edge entering LOAD so it is stable during the strobe.
      if (state_nxt == S_LOAD) begin
        load_val <= (state == S_FILL) ? chart_data : chunk_buf;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            len_q      <= chart_len;
            chart_addr <= '0;
            chunk_idx  <= '0;
            step_idx   <= '0;
            tick       <= '0;
          end
        end
        S_FILL: chunk_buf <= chart_data;
        S_LOAD: begin
          tick     <= '0;
          step_idx <= '0;
          if (more_chunks) begin
            chart_addr <= next_chunk;
          end
        end
        S_RUN: begin
          if (!pause) begin
            if (tick_last) begin
              tick <= '0;
              if (!step_last) begin
                step_idx <= step_idx + 1'b1;
              end else if (more_chunks) begin
                chunk_idx <= next_chunk;
              end
            end else begin
              tick <= tick + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_note_track_sequencer.sv
// tb/tb_note_track_sequencer.sv - scoreboard bench for note_track_sequencer
module tb_note_track_sequencer;

  localparam int W  = 10;
  localparam int T  = 4;
  localparam int AW = 4;
  localparam int SW = 7;

  localparam int K_LOAD  = 0;
  localparam int K_SHIFT = 1;
  localparam int K_DONE  = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic [AW-1:0] chart_len = '0;
  logic [AW-1:0] chart_addr;
  logic [W-1:0]  chart_data = '0;
  logic [W-1:0]  load_val;
  logic          load_n, shift, shift_in, busy, done;
  logic [AW-1:0] chunk_idx;
  logic [SW-1:0] step_idx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic sb_off = 1'b0;

  logic [W-1:0] rom [16];
  logic [W-1:0] shreg = '0;

  typedef struct {
    int kind;
    int cyc;
    int data;
    int aux;
  } ev_t;
  ev_t exp_q[$];

  note_track_sequencer #(
    .WIDTH(W), .TICKS_PER_SHIFT(T), .ADDR_W(AW), .STEP_W(SW)
  ) dut (
    .clock(clk), .reset(reset), .start(start), .pause(pause),
    .chart_len(chart_len), .chart_addr(chart_addr), .chart_data(chart_data),
    .load_val(load_val), .load_n(load_n), .shift(shift), .shift_in(shift_in),
    .busy(busy), .done(done), .chunk_idx(chunk_idx), .step_idx(step_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) chart_data <= rom[chart_addr];

  // Downstream shifter stand-in: parallel load on load_n, shift left on shift.
  always @(posedge clk) begin
    if (!load_n) shreg <= load_val;
    else if (shift) shreg <= {shreg[W-2:0], shift_in};
  end

  // Monitor: every strobe seen must match the head of the expected queue.
  always @(negedge clk) begin
    ev_t e;
    int k, d, a;
    if (!reset && !sb_off) begin
      if (!load_n && shift) begin
        checks++;
        errors++;
        $display("FAIL overlap: load_n=0 and shift=1 at cyc %0d (required never)", cyc);
      end
      if (!load_n || shift || done) begin
        if (!load_n) begin k = K_LOAD; d = int'(load_val); a = int'(chunk_idx); end
        else if (shift) begin k = K_SHIFT; d = int'(shift_in); a = int'(step_idx); end
        else begin k = K_DONE; d = int'(busy); a = 0; end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected: kind %0d at cyc %0d, required no event", k, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.kind != k || e.cyc != cyc || e.data != d || e.aux != a) begin
            errors++;
            $display("FAIL event: got kind %0d cyc %0d data %0h aux %0d, required kind %0d cyc %0d data %0h aux %0d",
                     k, cyc, d, a, e.kind, e.cyc, e.data, e.aux);
          end
        end
      end
    end
  end

  function automatic ev_t mk(int k, int c, int d, int a);
    ev_t e;
    e.kind = k; e.cyc = c; e.data = d; e.aux = a;
    return e;
  endfunction

  // Expected strobe timeline for a start accepted by the edge that makes cyc==acc.
  // Load in cyc acc+2; pause counts cycles p0..p0+plen-1 as frozen.
  task automatic gen_play(int acc, int len, int p0, int plen);
    int l, c, cnt, n;
    if (len == 0) begin
      exp_q.push_back(mk(K_DONE, acc, 1, 0));
      return;
    end
    l = acc + 2;
    for (int ch = 0; ch < len; ch++) begin
      exp_q.push_back(mk(K_LOAD, l, int'(rom[ch]), ch));
      c = l;
      cnt = 0;
      n = 0;
      while (n < W) begin
        c++;
        if (!(c >= p0 && c < p0 + plen)) begin
          if (cnt == T - 1) begin
            exp_q.push_back(mk(K_SHIFT, c, 0, n));
            n++;
            cnt = 0;
          end else begin
            cnt++;
          end
        end
      end
      l = c + 1;
    end
    exp_q.push_back(mk(K_DONE, l, 1, 0));
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) tick1();
  endtask

  // Drive start for one clock; returns the cyc value during the cycle after acceptance.
  task automatic pulse_start(input int len, output int acc);
    chart_len = AW'(len);
    start = 1'b1;
    acc = cyc + 1;
    tick1();
    start = 1'b0;
  endtask

  task automatic drain(string name, int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      tick1();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain: %0d events outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (8) tick1();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle busy: got %b required 0", name, busy);
    end
  endtask

  task automatic chk(string name, int got, int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  initial begin
    int acc;
    for (int i = 0; i < 16; i++) rom[i] = '0;

    // Power-on reset
    reset = 1'b1;
    repeat (3) tick1();
    reset = 1'b0;
    chk("rst load_n", int'(load_n), 1);
    chk("rst shift", int'(shift), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst chart_addr", int'(chart_addr), 0);
    chk("rst chunk_idx", int'(chunk_idx), 0);
    chk("rst step_idx", int'(step_idx), 0);
    chk("rst load_val", int'(load_val), 0);
    chk("rst shift_in", int'(shift_in), 0);

    // 1: reset held 3 clocks in the middle of RUN aborts with no done
    rom[0] = 10'h005; rom[1] = 10'h006; rom[2] = 10'h007;
    sb_off = 1'b1;
    pulse_start(3, acc);
    wait_cyc(acc + 20);
    chk("t1 busy before reset", int'(busy), 1);
    reset = 1'b1;
    repeat (3) tick1();
    reset = 1'b0;
    chk("t1 load_n", int'(load_n), 1);
    chk("t1 shift", int'(shift), 0);
    chk("t1 busy", int'(busy), 0);
    chk("t1 done", int'(done), 0);
    chk("t1 step_idx", int'(step_idx), 0);
    sb_off = 1'b0;
    repeat (60) tick1();

    // 2: single chunk; a start while busy must be ignored
    rom[0] = 10'h2A5;
    pulse_start(1, acc);
    gen_play(acc, 1, -100, 0);
    wait_cyc(acc + 20);
    chart_len = 4'd5;
    start = 1'b1;
    tick1();
    start = 1'b0;
    drain("t2", 200);
    chk("t2 shifter empty", int'(shreg), 0);

    // 3: three chunks back to back
    rom[0] = 10'h001; rom[1] = 10'h002; rom[2] = 10'h003;
    pulse_start(3, acc);
    gen_play(acc, 3, -100, 0);
    drain("t3", 400);

    // 4: pause 7 clocks right after the first shift stretches that gap from 4 to 11
    rom[0] = 10'h155;
    pulse_start(1, acc);
    gen_play(acc, 1, acc + 7, 7);
    wait_cyc(acc + 7);
    pause = 1'b1;
    wait_cyc(acc + 14);
    pause = 1'b0;
    drain("t4", 200);

    // 5: empty chart finishes immediately with no load or shift
    pulse_start(0, acc);
    gen_play(acc, 0, -100, 0);
    drain("t5", 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
